// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit path: digit code limits, the decoder
// state encoding and a digit validity helper.
package bcd_pkg;

  localparam logic [3:0] BCD_INVALID = 4'b1111;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } state_t;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add: acc*10 + digit as a shift-add,
// evaluated at BIN_W+4 bits and truncated to BIN_W.
module bcd_mac10 #(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] result
);

  logic [BIN_W+3:0] acc_ext;
  logic [BIN_W+3:0] digit_ext;

  always_comb begin
    acc_ext   = {4'b0000, acc};
    digit_ext = {{BIN_W{1'b0}}, digit};
    result    = BIN_W'((acc_ext << 3) + (acc_ext << 1) + digit_ext);
  end

endmodule

// File: rtl/bcd_stream_decoder.sv
// Reassembles a serial MSD-first BCD digit stream into a binary value and
// presents it, with error and digit-count status, on a valid/ready output.
module bcd_stream_decoder
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int BIN_W   = 14,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out_bin,
  output logic             out_err,
  output logic [CNT_W-1:0] out_ndig
);

  state_t           state, state_nxt;
  logic [BIN_W-1:0] acc, acc_nxt, acc_mac;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err, err_nxt;
  logic             digit_ok;
  logic             accept;

  assign digit_ok = is_bcd(in_digit);
  assign accept   = in_valid && in_ready;

  // Invalid digits contribute zero but still shift the accumulator.
  bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
    .acc    (acc),
    .digit  (digit_ok ? in_digit : 4'd0),
    .result (acc_mac)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    err_nxt   = err;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          if (cnt < CNT_W'(NDIGITS)) begin
            acc_nxt = acc_mac;
            cnt_nxt = cnt + CNT_W'(1);
            if (!digit_ok) err_nxt = 1'b1;
          end else begin
            // Excess digit: consumed and flagged, value and count held.
            err_nxt = 1'b1;
          end
          state_nxt = in_last ? ST_DONE : ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready  = !rst && (state != ST_DONE);
  assign out_valid = (state == ST_DONE);
  assign out_bin   = acc;
  assign out_err   = err;
  assign out_ndig  = cnt;

endmodule

// File: tb/tb_bcd_stream_decoder.sv
// Self-checking bench for bcd_stream_decoder: directed frames plus random
// frames compared against an arithmetic reference of the frame value.
module tb_bcd_stream_decoder;
  import bcd_pkg::*;

  localparam int NDIGITS = 4;
  localparam int BIN_W   = 14;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_digit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] out_bin;
  logic             out_err;
  logic [CNT_W-1:0] out_ndig;

  int checks   = 0;
  int failures = 0;
  logic [3:0] frame_q[$];

  bcd_stream_decoder #(
    .NDIGITS (NDIGITS),
    .BIN_W   (BIN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_err   (out_err),
    .out_ndig  (out_ndig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_in_ready", 32'(in_ready), 0);
      chk("rst_hold_out_valid", 32'(out_valid), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    chk("post_rst_out_bin", 32'(out_bin), 0);
    chk("post_rst_out_err", 32'(out_err), 0);
    chk("post_rst_out_ndig", 32'(out_ndig), 0);
  endtask

  // Sends frame_q with random in_valid gaps, then holds the result for
  // `hold` extra cycles with a junk digit offered, then accepts it.
  task automatic run_frame(input int hold, input int gap_max);
    int   eb = 0;
    int   en = 0;
    logic ee = 1'b0;
    foreach (frame_q[i]) begin
      if (en < NDIGITS) begin
        eb = eb * 10 + ((frame_q[i] <= 4'd9) ? int'(frame_q[i]) : 0);
        en++;
        if (frame_q[i] > 4'd9) ee = 1'b1;
      end else begin
        ee = 1'b1;
      end
    end
    out_ready = 1'b0;
    for (int i = 0; i < frame_q.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(negedge clk);
        in_valid = 1'b0;
        chk("gap_in_ready", 32'(in_ready), 1);
        chk("gap_out_valid", 32'(out_valid), 0);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_digit = frame_q[i];
      in_last  = (i == frame_q.size() - 1);
      chk("digit_in_ready", 32'(in_ready), 1);
      chk("digit_out_valid", 32'(out_valid), 0);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_digit = 4'($urandom);
    in_last  = 1'($urandom);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("done_out_valid", 32'(out_valid), 1);
      chk("done_in_ready", 32'(in_ready), 0);
      chk("out_bin", 32'(out_bin), 32'(eb));
      chk("out_err", 32'(out_err), 32'(ee));
      chk("out_ndig", 32'(out_ndig), 32'(en));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk("after_hs_out_valid", 32'(out_valid), 0);
    chk("after_hs_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_digit  = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    apply_reset();

    frame_q = '{4'd1, 4'd2, 4'd3, 4'd4};
    run_frame(0, 0);
    frame_q = '{4'd0};
    run_frame(0, 0);
    frame_q = '{4'd9};
    run_frame(0, 0);
    frame_q = '{4'd5, BCD_INVALID, 4'd7};
    run_frame(0, 1);
    frame_q = '{4'd4, 4'd2};
    run_frame(0, 0);
    frame_q = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd8};
    run_frame(0, 0);
    frame_q = '{4'd8, 4'd6};
    run_frame(5, 0);
    frame_q = '{4'd3, 4'd3};
    run_frame(0, 0);

    // Partial frame discarded by reset.
    @(negedge clk);
    in_valid = 1'b1; in_digit = 4'd3; in_last = 1'b0;
    @(negedge clk);
    in_digit = 4'd1;
    @(negedge clk);
    in_valid = 1'b0;
    apply_reset();
    frame_q = '{4'd2};
    run_frame(0, 0);

    // Pending result discarded by reset.
    @(negedge clk);
    in_valid = 1'b1; in_digit = 4'd7; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("pending_out_valid", 32'(out_valid), 1);
    apply_reset();
    frame_q = '{4'd6, 4'd1};
    run_frame(1, 0);

    for (int f = 0; f < 40; f++) begin
      int len;
      len = int'($urandom_range(1, 6));
      frame_q = {};
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) < 8) frame_q.push_back(4'($urandom_range(0, 9)));
        else frame_q.push_back(4'($urandom_range(10, 15)));
      end
      run_frame(int'($urandom_range(0, 3)), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
